// File: rtl/report_sequencer_pkg.sv
// report_pkg: shared types and constants for the race-time report sequencer.
// Optional build macro REPORT_PREFIX_EN selects the "T=" prefixed message.
package report_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_DONE  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_T     = 8'h54;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;

    localparam int MSG_LEN_BASE   = 10;
    localparam int MSG_LEN_PREFIX = 12;
    localparam int PREFIX_LEN     = MSG_LEN_PREFIX - MSG_LEN_BASE;

`ifdef REPORT_PREFIX_EN
    localparam int MSG_LEN = MSG_LEN_PREFIX;
`else
    localparam int MSG_LEN = MSG_LEN_BASE;
`endif

    localparam int IDX_W = 4;

    localparam int unsigned DEF_CLK_FREQ   = 25_000_000;
    localparam int unsigned DEF_TIMEOUT_MS = 10;
    localparam int unsigned TIMEOUT_CYCLES = DEF_CLK_FREQ / 1000 * DEF_TIMEOUT_MS;

    // Per-byte stall budget in clock cycles for a given clock and timeout.
    function automatic int unsigned timeout_cycles(
        input int unsigned clk_freq,
        input int unsigned timeout_ms
    );
        return clk_freq / 1000 * timeout_ms;
    endfunction

    // Decimal digit to ASCII; non-decimal nibbles are shown as '?'.
    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return ASCII_ZERO + {4'h0, d};
        end
        return ASCII_QMARK;
    endfunction

endpackage

// File: rtl/report_sequencer_if.sv
// Start request, time value and byte-stream handshake of the report sequencer.
// The sequencer is the master of the byte stream toward the UART.
interface report_sequencer_if;

    logic        start_in;
    logic [23:0] time_bcd_in;
    logic [7:0]  tx_data_out;
    logic        tx_valid_out;
    logic        tx_ready_in;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    modport master (
        input  start_in,
        input  time_bcd_in,
        input  tx_ready_in,
        output tx_data_out,
        output tx_valid_out,
        output busy_out,
        output done_out,
        output error_out
    );

    modport slave (
        output start_in,
        output time_bcd_in,
        output tx_ready_in,
        input  tx_data_out,
        input  tx_valid_out,
        input  busy_out,
        input  done_out,
        input  error_out
    );

endinterface

// File: rtl/report_sequencer_char_mux.sv
// report_char_mux: byte index plus latched BCD time to ASCII character.
// With REPORT_PREFIX_EN the first two bytes are "T=" and the rest shift up.
module report_char_mux
    import report_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic [23:0]      digits,
    output logic [7:0]       char_out
);

    logic [IDX_W-1:0] pos;
    logic [7:0]       body;

`ifdef REPORT_PREFIX_EN
    assign pos = idx - IDX_W'(PREFIX_LEN);
`else
    assign pos = idx;
`endif

    // Time body: MM:SS.cc followed by CR LF.
    always_comb begin
        body = 8'h00;
        unique case (pos)
            4'd0:    body = bcd_to_ascii(digits[23:20]);
            4'd1:    body = bcd_to_ascii(digits[19:16]);
            4'd2:    body = ASCII_COLON;
            4'd3:    body = bcd_to_ascii(digits[15:12]);
            4'd4:    body = bcd_to_ascii(digits[11:8]);
            4'd5:    body = ASCII_DOT;
            4'd6:    body = bcd_to_ascii(digits[7:4]);
            4'd7:    body = bcd_to_ascii(digits[3:0]);
            4'd8:    body = ASCII_CR;
            4'd9:    body = ASCII_LF;
            default: body = 8'h00;
        endcase
    end

`ifdef REPORT_PREFIX_EN
    // Prefix bytes ahead of the time body.
    always_comb begin
        char_out = body;
        unique case (1'b1)
            (idx == 4'd0): char_out = ASCII_T;
            (idx == 4'd1): char_out = ASCII_EQ;
            default:       char_out = body;
        endcase
    end
`else
    assign char_out = body;
`endif

endmodule

// File: rtl/report_sequencer.sv
// report_sequencer: sends the latched race time as ASCII over a valid/ready
// byte stream with a per-byte timeout. Build macro: REPORT_PREFIX_EN.
module report_sequencer
    import report_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned TIMEOUT_MS = 10
)(
    input  logic               clk,
    input  logic               reset_global,
    report_sequencer_if.master bus
);

    localparam int unsigned TO_CYC = timeout_cycles(CLK_FREQ, TIMEOUT_MS);
    localparam int          CNT_W  = $clog2(TO_CYC) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             start_q;
    logic             armed;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] wait_cnt;
    logic [23:0]      digits;
    logic             error_q;
    logic [7:0]       char_byte;

    logic accept;
    logic xfer;
    logic last;
    logic stall_to;

    // armed blocks a start that was already high when reset released.
    assign accept = (state == S_IDLE) && bus.start_in && !start_q && armed;
    assign xfer   = (state == S_SEND) && bus.tx_ready_in;
    assign last   = (idx == IDX_W'(MSG_LEN - 1));
    assign stall_to = (state == S_SEND) && !bus.tx_ready_in
                    && (wait_cnt == CNT_W'(TO_CYC - 1));

    report_char_mux u_mux (
        .idx      (idx),
        .digits   (digits),
        .char_out (char_byte)
    );

    // State register.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (xfer && last) begin
                    state_nxt = S_DONE;
                end else if (stall_to) begin
                    state_nxt = S_ABORT;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; data is zero whenever nothing is offered.
    always_comb begin
        bus.tx_valid_out = (state == S_SEND);
        bus.tx_data_out  = (state == S_SEND) ? char_byte : 8'h00;
        bus.busy_out     = (state != S_IDLE);
        bus.done_out     = (state == S_DONE);
        bus.error_out    = error_q;
    end

    // Start edge detect and re-arm after start_in has been seen low.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            start_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            start_q <= bus.start_in;
            if (!bus.start_in) begin
                armed <= 1'b1;
            end
        end
    end

    // Time snapshot taken at acceptance so later input changes are ignored.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            digits <= 24'h0;
        end else if (accept) begin
            digits <= bus.time_bcd_in;
        end
    end

    // Byte index: advances on each transfer, parked at 0 outside S_SEND.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            idx <= '0;
        end else if (state != S_SEND) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= last ? '0 : idx + 1'b1;
        end
    end

    // Stall counter: cycles offered but not taken, saturating at the limit.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            wait_cnt <= '0;
        end else if ((state != S_SEND) || xfer) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(TO_CYC)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag, cleared by the next accepted start.
    always_ff @(posedge clk or posedge reset_global) begin
        if (reset_global) begin
            error_q <= 1'b0;
        end else if (accept) begin
            error_q <= 1'b0;
        end else if (stall_to && !xfer) begin
            error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_report_sequencer.sv
// tb_report_sequencer: randomized self-checking bench for report_sequencer
// against a string-level message model. Honours REPORT_PREFIX_EN.
module tb_report_sequencer;

    logic clk = 1'b0;
    logic reset_global;

    always #5 clk = ~clk;

    report_sequencer_if bus();

    report_sequencer #(
        .CLK_FREQ   (1000),
        .TIMEOUT_MS (10)
    ) dut (
        .clk          (clk),
        .reset_global (reset_global),
        .bus          (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt   = 0;
    int         vcyc       = 0;
    int         ncyc       = 0;
    int         first_xfer = 0;
    int         last_xfer  = 0;
    int         rmode      = 0;
    logic       pend       = 1'b0;
    logic [7:0] pend_data  = 8'h00;

    // Monitor: collects transfers, done pulses and checks data holds while stalled.
    always @(negedge clk) begin
        ncyc++;
        if (reset_global) begin
            pend = 1'b0;
        end else begin
            if (pend && bus.tx_valid_out) begin
                checks++;
                if (bus.tx_data_out !== pend_data) begin
                    failures++;
                    $display("FAIL hold_stable data=%02h required=%02h",
                             bus.tx_data_out, pend_data);
                end
            end
            if (bus.tx_valid_out) vcyc++;
            if (bus.tx_valid_out && bus.tx_ready_in) begin
                if (got_q.size() == 0) first_xfer = ncyc;
                last_xfer = ncyc;
                got_q.push_back(bus.tx_data_out);
            end
            if (bus.done_out) done_cnt++;
            pend      = bus.tx_valid_out && !bus.tx_ready_in;
            pend_data = bus.tx_data_out;
        end
    end

    // Ready generator: 0 always, 1 one-in-three, 2 stuck low, 3 random (max 4 stalls).
    initial begin
        int cyc;
        int stall;
        cyc   = 0;
        stall = 0;
        bus.tx_ready_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rmode)
                0: bus.tx_ready_in = 1'b1;
                1: bus.tx_ready_in = (cyc % 3 == 0);
                2: bus.tx_ready_in = 1'b0;
                default: begin
                    bus.tx_ready_in = ($urandom_range(0, 1) == 1) || (stall >= 4);
                end
            endcase
            stall = bus.tx_ready_in ? 0 : stall + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected message from the time value, built as text.
    task automatic model(input logic [23:0] bcd);
        logic [3:0] nib;
        exp_q.delete();
`ifdef REPORT_PREFIX_EN
        exp_q.push_back("T");
        exp_q.push_back("=");
`endif
        for (int i = 0; i < 6; i++) begin
            nib = bcd[23 - 4 * i -: 4];
            exp_q.push_back(nib < 10 ? 8'h30 + {4'h0, nib} : "?");
            if (i == 1) exp_q.push_back(":");
            if (i == 3) exp_q.push_back(".");
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_msg(input string name);
        int n;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d required=%0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_byte%0d got=%02h required=%02h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            failures++;
            $display("FAIL %s_done_timeout got=none required=pulse", name);
        end
    endtask

    task automatic finish_msg(input int base, input string name);
        wait_done(base, 300, name);
        tick();
        tick();
        check_msg(name);
        checks++;
        if (done_cnt - base != 1) begin
            failures++;
            $display("FAIL %s_done_count got=%0d required=1", name, done_cnt - base);
        end
        checks++;
        if (bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_after got=%b required=0", name, bus.busy_out);
        end
    endtask

    task automatic run_msg(input logic [23:0] bcd, input string name);
        int base;
        model(bcd);
        got_q.delete();
        base = done_cnt;
        bus.time_bcd_in = bcd;
        bus.start_in    = 1'b1;
        tick();
        bus.start_in    = 1'b0;
        finish_msg(base, name);
    endtask

    task automatic test_reset();
        bus.start_in    = 1'b0;
        bus.time_bcd_in = 24'h0;
        reset_global    = 1'b1;
        repeat (3) tick();
        checks += 5;
        if (bus.tx_valid_out !== 1'b0) begin
            failures++; $display("FAIL rst_valid got=%b required=0", bus.tx_valid_out);
        end
        if (bus.tx_data_out !== 8'h00) begin
            failures++; $display("FAIL rst_data got=%02h required=00", bus.tx_data_out);
        end
        if (bus.busy_out !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%b required=0", bus.busy_out);
        end
        if (bus.done_out !== 1'b0) begin
            failures++; $display("FAIL rst_done got=%b required=0", bus.done_out);
        end
        if (bus.error_out !== 1'b0) begin
            failures++; $display("FAIL rst_error got=%b required=0", bus.error_out);
        end
        reset_global = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int base;
        rmode = 0;
        tick();
        model(24'h012345);
        got_q.delete();
        base = done_cnt;
        bus.time_bcd_in = 24'h012345;
        bus.start_in    = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.tx_valid_out !== 1'b0) begin
            failures++; $display("FAIL basic_valid_early got=%b required=0", bus.tx_valid_out);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_valid_out !== 1'b1 || bus.tx_data_out !== exp_q[0]) begin
            failures++;
            $display("FAIL basic_first got=%b/%02h required=1/%02h",
                     bus.tx_valid_out, bus.tx_data_out, exp_q[0]);
        end
        tick();
        bus.start_in = 1'b0;
        finish_msg(base, "basic");
        checks++;
        if (last_xfer - first_xfer != exp_q.size() - 1) begin
            failures++;
            $display("FAIL basic_span got=%0d required=%0d",
                     last_xfer - first_xfer, exp_q.size() - 1);
        end
    endtask

    task automatic test_throttled();
        rmode = 1;
        tick();
        run_msg(24'h012345, "throttled");
        run_msg(24'h0A0000, "qmark");
    endtask

    task automatic test_random();
        logic [23:0] bcd;
        for (int i = 0; i < 6; i++) begin
            bcd   = 24'($urandom);
            rmode = ($urandom_range(0, 2) == 0) ? 1 : 3;
            tick();
            run_msg(bcd, "random");
        end
    endtask

    task automatic test_timeout();
        int base;
        rmode = 2;
        tick();
        got_q.delete();
        base = done_cnt;
        vcyc = 0;
        bus.time_bcd_in = 24'h112233;
        bus.start_in    = 1'b1;
        tick();
        bus.start_in    = 1'b0;
        repeat (20) tick();
        checks += 5;
        if (vcyc != 10) begin
            failures++; $display("FAIL to_valid_cycles got=%0d required=10", vcyc);
        end
        if (bus.error_out !== 1'b1 || bus.tx_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL to_flags got=err%b/valid%b required=err1/valid0",
                     bus.error_out, bus.tx_valid_out);
        end
        if (done_cnt != base) begin
            failures++; $display("FAIL to_done got=%0d required=0", done_cnt - base);
        end
        if (got_q.size() != 0) begin
            failures++; $display("FAIL to_xfers got=%0d required=0", got_q.size());
        end
        if (bus.busy_out !== 1'b0) begin
            failures++; $display("FAIL to_busy got=%b required=0", bus.busy_out);
        end
        rmode = 0;
        model(24'h112233);
        base = done_cnt;
        bus.start_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.error_out !== 1'b0) begin
            failures++; $display("FAIL to_error_clear got=%b required=0", bus.error_out);
        end
        tick();
        bus.start_in = 1'b0;
        finish_msg(base, "after_to");
    endtask

    task automatic test_start_hold();
        int base;
        rmode = 1;
        tick();
        model(24'h594321);
        got_q.delete();
        base = done_cnt;
        bus.time_bcd_in = 24'h594321;
        bus.start_in    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 1) bus.time_bcd_in = 24'h999999;
            if (i == 6) bus.start_in = 1'b0;
            if (i == 7) bus.start_in = 1'b1;
        end
        bus.start_in = 1'b0;
        finish_msg(base, "hold");
    endtask

    task automatic test_reset_mid();
        int n;
        rmode = 0;
        tick();
        got_q.delete();
        bus.time_bcd_in = 24'h135792;
        bus.start_in    = 1'b1;
        n = 0;
        while (got_q.size() < 4 && n < 50) begin
            tick();
            n++;
        end
        reset_global = 1'b1;
        #1;
        checks += 2;
        if (got_q.size() != 4) begin
            failures++; $display("FAIL mid_pre_count got=%0d required=4", got_q.size());
        end
        if (bus.tx_valid_out !== 1'b0 || bus.tx_data_out !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset_out got=%b/%02h required=0/00",
                     bus.tx_valid_out, bus.tx_data_out);
        end
        tick();
        tick();
        reset_global = 1'b0;
        got_q.delete();
        repeat (20) tick();
        checks += 2;
        if (got_q.size() != 0) begin
            failures++; $display("FAIL mid_no_resume got=%0d required=0", got_q.size());
        end
        if (bus.busy_out !== 1'b0) begin
            failures++; $display("FAIL mid_busy got=%b required=0", bus.busy_out);
        end
        bus.start_in = 1'b0;
        tick();
        run_msg(24'h135792, "mid_restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throttled();
        test_random();
        test_timeout();
        test_start_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
